// File: rtl/led_color_sequencer.sv
// rtl/led_color_sequencer.sv - four-step RGB LED pattern player driven by colour/duration registers
module led_color_sequencer #(
  parameter int TICK_DIV = 12000
) (
  input  logic        WBs_CLK_i,
  input  logic        WBs_RST_i,
  input  logic        enable_i,
  input  logic [2:0]  color0,
  input  logic [2:0]  color1,
  input  logic [2:0]  color2,
  input  logic [2:0]  color3,
  input  logic [11:0] duration0,
  input  logic [11:0] duration1,
  input  logic [11:0] duration2,
  input  logic [11:0] duration3,
  output logic [2:0]  rgb_o,
  output logic [1:0]  step_o,
  output logic        wrap_o,
  output logic        busy_o
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t        state;
  logic [PW-1:0] prescaler;
  logic [11:0]   dur_cnt;
  logic [11:0]   cur_duration;
  logic [2:0]    cur_color;
  logic          tick;

  // Select the register pair for the current step; only consumed in LOAD.
  always_comb begin
    cur_duration = duration0;
    cur_color    = color0;
    case (step_o)
      2'd0: begin cur_duration = duration0; cur_color = color0; end
      2'd1: begin cur_duration = duration1; cur_color = color1; end
      2'd2: begin cur_duration = duration2; cur_color = color2; end
      2'd3: begin cur_duration = duration3; cur_color = color3; end
      default: begin cur_duration = duration0; cur_color = color0; end
    endcase
  end

  assign tick = (state == RUN) && (prescaler == PRESC_LAST);

  // Sequencer FSM with registered LED drive, step index, wrap pulse and busy flag.
  always_ff @(posedge WBs_CLK_i) begin
    if (WBs_RST_i || !enable_i) begin
      state     <= IDLE;
      rgb_o     <= 3'd0;
      step_o    <= 2'd0;
      wrap_o    <= 1'b0;
      busy_o    <= 1'b0;
      prescaler <= '0;
      dur_cnt   <= 12'd0;
    end else begin
      wrap_o <= 1'b0;
      case (state)
        IDLE: begin
          state  <= LOAD;
          busy_o <= 1'b1;
        end
        LOAD: begin
          busy_o <= 1'b1;
          if (cur_duration != 12'd0) begin
            dur_cnt   <= cur_duration;
            prescaler <= '0;
            rgb_o     <= cur_color;
            state     <= RUN;
          end else begin
            // Zero-length step: blank and move on without leaving LOAD.
            rgb_o  <= 3'd0;
            step_o <= step_o + 2'd1;
            wrap_o <= (step_o == 2'd3);
          end
        end
        RUN: begin
          busy_o <= 1'b1;
          if (tick) begin
            prescaler <= '0;
            dur_cnt   <= dur_cnt - 12'd1;
            if (dur_cnt == 12'd1) begin
              // rgb_o is left alone so the colour holds through the next LOAD.
              step_o <= step_o + 2'd1;
              wrap_o <= (step_o == 2'd3);
              state  <= LOAD;
            end
          end else begin
            prescaler <= prescaler + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          rgb_o  <= 3'd0;
          step_o <= 2'd0;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_color_sequencer.sv
// tb/tb_led_color_sequencer.sv - self-checking bench for led_color_sequencer
module tb_led_color_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [2:0]  color0, color1, color2, color3;
  logic [11:0] duration0, duration1, duration2, duration3;
  logic [2:0]  rgb;
  logic [1:0]  step;
  logic        wrap;
  logic        busy;

  int checks = 0;
  int errors = 0;

  led_color_sequencer #(.TICK_DIV(4)) dut (
    .WBs_CLK_i (clk),
    .WBs_RST_i (rst),
    .enable_i  (enable),
    .color0    (color0),
    .color1    (color1),
    .color2    (color2),
    .color3    (color3),
    .duration0 (duration0),
    .duration1 (duration1),
    .duration2 (duration2),
    .duration3 (duration3),
    .rgb_o     (rgb),
    .step_o    (step),
    .wrap_o    (wrap),
    .busy_o    (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][2:0]  col;
    logic [3:0][11:0] dur;
    int               period;
    int               step1;
    logic [7:0][7:0]  cnt;
  } vec_t;

  vec_t vecs[5];

  int m_period;
  int m_step1;
  int m_nobusy;
  int m_cnt[8];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_wrap(input int bound);
    int k;
    k = 0;
    while (!wrap && k < bound) begin
      cyc();
      k++;
    end
    check("wrap_reached", int'(wrap), 1);
  endtask

  // Starting on a wrap cycle, tally one full period up to the next wrap.
  task automatic measure();
    m_period = 0;
    m_step1  = 0;
    m_nobusy = 0;
    for (int v = 0; v < 8; v++) m_cnt[v] = 0;
    do begin
      m_cnt[rgb]++;
      if (step == 2'd1) m_step1++;
      if (!busy) m_nobusy++;
      cyc();
      m_period++;
    end while (!wrap && m_period < 20000);
  endtask

  task automatic do_reset();
    enable = 1'b0;
    rst    = 1'b1;
    cyc();
    rst    = 1'b0;
  endtask

  task automatic load_cfg(input vec_t v);
    color0 = v.col[0]; color1 = v.col[1]; color2 = v.col[2]; color3 = v.col[3];
    duration0 = v.dur[0]; duration1 = v.dur[1]; duration2 = v.dur[2]; duration3 = v.dur[3];
  endtask

  // Enable from IDLE and confirm step 0 replays from its start (6 edges to reach step 1).
  task automatic restart_check(input string tag);
    int k;
    enable = 1'b1;
    cyc();
    check({tag, "_load_busy"}, int'(busy), 1);
    check({tag, "_load_rgb"}, int'(rgb), 0);
    cyc();
    check({tag, "_run_rgb"}, int'(rgb), 1);
    check({tag, "_run_step"}, int'(step), 0);
    k = 2;
    while (step != 2'd1 && k < 50) begin
      cyc();
      k++;
    end
    check({tag, "_edges_to_step1"}, k, 6);
  endtask

  task automatic reach_step2();
    int k;
    k = 0;
    while (step != 2'd2 && k < 100) begin
      cyc();
      k++;
    end
    check("reach_step2", int'(step), 2);
    cyc(); cyc(); cyc();
  endtask

  initial begin
    int k;
    rst = 1'b1; enable = 1'b0;
    color0 = 3'd0; color1 = 3'd0; color2 = 3'd0; color3 = 3'd0;
    duration0 = 12'd0; duration1 = 12'd0; duration2 = 12'd0; duration3 = 12'd0;

    vecs[0] = '{col: {3'd7, 3'd4, 3'd2, 3'd1}, dur: {12'd4, 12'd3, 12'd2, 12'd1},
                period: 44, step1: 9,
                cnt: {8'd17, 8'd0, 8'd0, 8'd13, 8'd0, 8'd9, 8'd5, 8'd0}};
    vecs[1] = '{col: {3'd7, 3'd4, 3'd2, 3'd1}, dur: {12'd4, 12'd3, 12'd0, 12'd1},
                period: 36, step1: 1,
                cnt: {8'd17, 8'd0, 8'd0, 8'd13, 8'd0, 8'd0, 8'd5, 8'd1}};
    vecs[2] = '{col: {3'd7, 3'd4, 3'd2, 3'd1}, dur: {12'd0, 12'd0, 12'd0, 12'd0},
                period: 4, step1: 1,
                cnt: {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd4}};
    vecs[3] = '{col: {3'd1, 3'd2, 3'd4, 3'd7}, dur: {12'd1, 12'd0, 12'd1, 12'd2},
                period: 20, step1: 5,
                cnt: {8'd9, 8'd0, 8'd0, 8'd5, 8'd0, 8'd0, 8'd5, 8'd1}};
    vecs[4] = '{col: {3'd2, 3'd6, 3'd5, 3'd3}, dur: {12'd2, 12'd0, 12'd0, 12'd0},
                period: 12, step1: 1,
                cnt: {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd9, 8'd0, 8'd3}};

    // Reset held 3 cycles, then released with enable low.
    cyc(); cyc(); cyc();
    check("rst_rgb", int'(rgb), 0);
    check("rst_step", int'(step), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_wrap", int'(wrap), 0);
    rst = 1'b0;
    cyc(); cyc();
    check("idle_rgb", int'(rgb), 0);
    check("idle_busy", int'(busy), 0);

    // Steady-state periods for each table entry.
    for (int i = 0; i < 5; i++) begin
      do_reset();
      load_cfg(vecs[i]);
      enable = 1'b1;
      wait_wrap(200);
      measure();
      measure();
      check($sformatf("v%0d_period", i), m_period, vecs[i].period);
      check($sformatf("v%0d_step1", i), m_step1, vecs[i].step1);
      check($sformatf("v%0d_notbusy", i), m_nobusy, 0);
      for (int v = 0; v < 8; v++)
        check($sformatf("v%0d_rgb%0d_cycles", i, v), m_cnt[v], int'(vecs[i].cnt[v]));
    end

    // Drop enable mid step 2, then restart.
    do_reset();
    load_cfg(vecs[0]);
    enable = 1'b1;
    reach_step2();
    enable = 1'b0;
    cyc();
    check("dis_rgb", int'(rgb), 0);
    check("dis_step", int'(step), 0);
    check("dis_busy", int'(busy), 0);
    restart_check("reen");

    // Same using reset mid step 2.
    reach_step2();
    rst = 1'b1;
    cyc();
    check("mrst_rgb", int'(rgb), 0);
    check("mrst_step", int'(step), 0);
    check("mrst_busy", int'(busy), 0);
    rst = 1'b0;
    restart_check("rerst");

    // Duration change during step 0 only affects the next visit.
    do_reset();
    load_cfg(vecs[0]);
    enable = 1'b1;
    wait_wrap(200);
    k = 0;
    while (step == 2'd0 && k < 100) begin
      if (k == 2) duration0 = 12'd3;
      cyc();
      k++;
    end
    check("dchg_cur_step0", k, 5);
    wait_wrap(200);
    k = 0;
    while (step == 2'd0 && k < 100) begin
      cyc();
      k++;
    end
    check("dchg_next_step0", k, 13);

    // Maximum duration runs its full length.
    duration0 = 12'hFFF;
    wait_wrap(200);
    k = 0;
    while (step == 2'd0 && k < 20000) begin
      cyc();
      k++;
    end
    check("dmax_step0", k, 16381);
    wait_wrap(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
